// File: rtl/dec_rle_expand.sv
// Expands JPEG run/value tokens into BLOCK_LEN signed coefficients per block (EOB/ZRL aware).
// First coefficient 1 cycle after token accept; 1 coef/cycle; single output register, stalls on coef_b.
module dec_rle_expand #(
    parameter int COEF_W    = 16,
    parameter int BLOCK_LEN = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       parsedToken_d,
    input  logic              parsedToken_e,
    input  logic              parsedToken_v,
    output logic              parsedToken_b,
    output logic [COEF_W-1:0] coef_d,
    output logic              coef_e,
    output logic              coef_v,
    input  logic              coef_b,
    output logic              err
);
    localparam int              IDX_W    = $clog2(BLOCK_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLOCK_LEN - 1);

    typedef enum logic [2:0] {
        FETCH, ZEROS, VALUE, FILL, PADEOS, SENDEOS, DONE
    } state_t;

    state_t            state_q, state_n;
    logic [IDX_W-1:0]  idx_q;
    logic [3:0]        run_q, run_n;
    logic              zrl_q, zrl_n;
    logic [COEF_W-1:0] val_q, val_n;

    logic              can_load, tok_acc, last_slot;
    logic              load, load_e, err_set;
    logic [COEF_W-1:0] load_d;

    logic [3:0]        tok_r, run_init;
    logic [COEF_W-1:0] tok_v;
    logic              is_eob, is_zrl;

    assign can_load      = !coef_v || !coef_b;
    assign last_slot     = (idx_q == IDX_LAST);
    assign parsedToken_b = (state_q != FETCH) || !can_load;
    assign tok_acc       = parsedToken_v && !parsedToken_b;

    assign tok_r    = parsedToken_d[15:12];
    assign tok_v    = COEF_W'($signed(parsedToken_d[11:0]));
    assign is_eob   = (parsedToken_d == 16'h0000);
    assign is_zrl   = (parsedToken_d == 16'hF000);
    // The first zero of a run leaves in the accept cycle, so only the rest is counted.
    assign run_init = is_zrl ? 4'd15 : 4'(tok_r - 4'd1);

    always_comb begin
        state_n = state_q;
        run_n   = run_q;
        zrl_n   = zrl_q;
        val_n   = val_q;
        load    = 1'b0;
        load_d  = '0;
        load_e  = 1'b0;
        err_set = 1'b0;
        case (state_q)
            FETCH: begin
                if (tok_acc) begin
                    if (parsedToken_e) begin
                        state_n = (idx_q != '0) ? PADEOS : SENDEOS;
                    end else if (idx_q == '0 || (tok_r == 4'd0 && !is_eob)) begin
                        load   = 1'b1;
                        load_d = tok_v;
                    end else begin
                        load = 1'b1;
                        if (is_eob) begin
                            state_n = last_slot ? FETCH : FILL;
                        end else begin
                            run_n = run_init;
                            zrl_n = is_zrl;
                            val_n = tok_v;
                            if (last_slot)
                                err_set = 1'b1;
                            else if (run_init == 4'd0)
                                state_n = VALUE;
                            else
                                state_n = ZEROS;
                        end
                    end
                end
            end
            ZEROS: begin
                if (can_load) begin
                    load  = 1'b1;
                    run_n = run_q - 4'd1;
                    if (last_slot) begin
                        // Block closed with zeros or a value still owed.
                        err_set = (run_n != 4'd0) || !zrl_q;
                        state_n = FETCH;
                    end else if (run_n == 4'd0) begin
                        state_n = zrl_q ? FETCH : VALUE;
                    end
                end
            end
            VALUE: begin
                if (can_load) begin
                    load    = 1'b1;
                    load_d  = val_q;
                    state_n = FETCH;
                end
            end
            FILL: begin
                if (can_load) begin
                    load = 1'b1;
                    if (last_slot)
                        state_n = FETCH;
                end
            end
            PADEOS: begin
                if (can_load) begin
                    load = 1'b1;
                    if (last_slot)
                        state_n = SENDEOS;
                end
            end
            SENDEOS: begin
                if (can_load) begin
                    load    = 1'b1;
                    load_e  = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = DONE;
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= FETCH;
            idx_q   <= '0;
            run_q   <= '0;
            zrl_q   <= 1'b0;
            val_q   <= '0;
            coef_v  <= 1'b0;
            coef_e  <= 1'b0;
            coef_d  <= '0;
            err     <= 1'b0;
        end else begin
            state_q <= state_n;
            run_q   <= run_n;
            zrl_q   <= zrl_n;
            val_q   <= val_n;
            if (load && !load_e)
                idx_q <= last_slot ? '0 : idx_q + IDX_W'(1);
            if (err_set)
                err <= 1'b1;
            if (load) begin
                coef_v <= 1'b1;
                coef_d <= load_d;
                coef_e <= load_e;
            end else if (!coef_b) begin
                coef_v <= 1'b0;
                coef_e <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dec_rle_expand.sv
// Bench for dec_rle_expand: token table, directed multi-cycle sequences and randomized streams vs a list-based model.
module tb_dec_rle_expand;
    localparam int BLK = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] parsedToken_d = '0;
    logic        parsedToken_e = 1'b0;
    logic        parsedToken_v = 1'b0;
    logic        parsedToken_b;
    logic [15:0] coef_d;
    logic        coef_e;
    logic        coef_v;
    logic        coef_b = 1'b0;
    logic        err;

    dec_rle_expand #(.COEF_W(16), .BLOCK_LEN(BLK)) dut (
        .clock(clock), .reset(reset),
        .parsedToken_d(parsedToken_d), .parsedToken_e(parsedToken_e),
        .parsedToken_v(parsedToken_v), .parsedToken_b(parsedToken_b),
        .coef_d(coef_d), .coef_e(coef_e), .coef_v(coef_v), .coef_b(coef_b),
        .err(err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed { logic e; logic [15:0] d; } tok_t;
    tok_t        tok_q[$];
    logic [15:0] got_d[$], exp_d[$];
    logic        got_e[$], exp_e[$];
    int          acc_cyc[$], out_cyc[$];
    logic        exp_err;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] sext(input logic [11:0] v);
        return {{4{v[11]}}, v};
    endfunction

    // Reference: each token becomes a list of coefficients, clipped at the block end.
    function automatic void model_expand();
        int          idx;
        int          room;
        logic [15:0] t;
        logic [15:0] items[$];
        idx = 0;
        exp_d.delete(); exp_e.delete(); exp_err = 1'b0;
        foreach (tok_q[i]) begin
            t = tok_q[i].d;
            items.delete();
            if (tok_q[i].e) begin
                for (int k = idx; k < BLK && idx != 0; k++) begin
                    exp_d.push_back(16'h0); exp_e.push_back(1'b0);
                end
                exp_d.push_back(16'h0); exp_e.push_back(1'b1);
                return;
            end
            if (idx == 0)
                items.push_back(sext(t[11:0]));
            else if (t == 16'h0000)
                repeat (BLK - idx) items.push_back(16'h0);
            else if (t == 16'hF000)
                repeat (16) items.push_back(16'h0);
            else begin
                repeat (int'(t[15:12])) items.push_back(16'h0);
                items.push_back(sext(t[11:0]));
            end
            room = BLK - idx;
            if (items.size() > room) exp_err = 1'b1;
            for (int k = 0; k < items.size() && k < room; k++) begin
                exp_d.push_back(items[k]); exp_e.push_back(1'b0);
            end
            idx = (idx + ((items.size() > room) ? room : items.size())) % BLK;
        end
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0; parsedToken_v = 1'b0; coef_b = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Drives tok_q, collects transfers; checks that a stalled output holds steady.
    task automatic run_tokens(input bit rand_b, input bit rand_v);
        int          sent = 0, idle = 0, n = 0;
        bit          offering = 0, prev_stall = 0;
        logic [15:0] prev_d = '0;
        logic        prev_e = 1'b0;
        got_d.delete(); got_e.delete(); acc_cyc.delete(); out_cyc.delete();
        forever begin
            @(negedge clock);
            coef_b = rand_b ? ($urandom_range(0, 1) == 1) : 1'b0;
            if (!offering && sent < tok_q.size() && (!rand_v || $urandom_range(0, 3) != 0))
                offering = 1;
            parsedToken_v = offering;
            if (offering) begin
                parsedToken_d = tok_q[sent].d;
                parsedToken_e = tok_q[sent].e;
            end
            #1;
            if (prev_stall) begin
                check("stall_v", 32'(coef_v), 32'd1);
                check("stall_d", 32'(coef_d), 32'(prev_d));
                check("stall_e", 32'(coef_e), 32'(prev_e));
            end
            prev_stall = coef_v && coef_b;
            prev_d = coef_d; prev_e = coef_e;
            if (parsedToken_v && !parsedToken_b) begin
                sent++; offering = 0; acc_cyc.push_back(cyc);
            end
            if (coef_v && !coef_b) begin
                got_d.push_back(coef_d); got_e.push_back(coef_e); out_cyc.push_back(cyc);
            end
            idle = (sent == tok_q.size() && !coef_v) ? idle + 1 : 0;
            if (idle >= 4) break;
            n++;
            if (n > 20000) begin
                miscompares++;
                $display("FAIL run_timeout: sent %0d of %0d tokens", sent, tok_q.size());
                break;
            end
        end
        @(negedge clock);
        parsedToken_v = 1'b0; coef_b = 1'b0;
    endtask

    task automatic compare_stream(input string name);
        model_expand();
        check({name, "_len"}, got_d.size(), exp_d.size());
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            check($sformatf("%s_d[%0d]", name, i), 32'(got_d[i]), 32'(exp_d[i]));
            check($sformatf("%s_e[%0d]", name, i), 32'(got_e[i]), 32'(exp_e[i]));
        end
        check({name, "_err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic push_tok(input logic [15:0] d);
        tok_q.push_back('{e: 1'b0, d: d});
    endtask

    typedef struct {
        logic [15:0] tok;
        int          pre;
        int          zeros;
        bit          has_val;
        logic [15:0] val;
        bit          err;
    } vec_t;
    vec_t tbl[15];

    initial begin
        tbl[0]  = '{16'h0FFF,  0,  0, 1'b1, 16'hFFFF, 1'b0};
        tbl[1]  = '{16'h37FF,  0,  0, 1'b1, 16'h07FF, 1'b0};
        tbl[2]  = '{16'h0000,  0,  0, 1'b1, 16'h0000, 1'b0};
        tbl[3]  = '{16'hF000,  0,  0, 1'b1, 16'h0000, 1'b0};
        tbl[4]  = '{16'h0800,  1,  0, 1'b1, 16'hF800, 1'b0};
        tbl[5]  = '{16'h5123,  5,  5, 1'b1, 16'h0123, 1'b0};
        tbl[6]  = '{16'h0000, 10, 54, 1'b0, 16'h0000, 1'b0};
        tbl[7]  = '{16'h0000, 63,  1, 1'b0, 16'h0000, 1'b0};
        tbl[8]  = '{16'hF000, 48, 16, 1'b0, 16'h0000, 1'b0};
        tbl[9]  = '{16'hF000, 49, 15, 1'b0, 16'h0000, 1'b1};
        tbl[10] = '{16'h3005, 60,  3, 1'b1, 16'h0005, 1'b0};
        tbl[11] = '{16'h3005, 61,  3, 1'b0, 16'h0000, 1'b1};
        tbl[12] = '{16'h1001, 63,  1, 1'b0, 16'h0000, 1'b1};
        tbl[13] = '{16'h0001, 63,  0, 1'b1, 16'h0001, 1'b0};
        tbl[14] = '{16'h2ABC, 62,  2, 1'b0, 16'h0000, 1'b1};

        do_reset();
        #1;
        check("rst_coef_v", 32'(coef_v), 32'd0);
        check("rst_coef_e", 32'(coef_e), 32'd0);
        check("rst_coef_d", 32'(coef_d), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_tok_b", 32'(parsedToken_b), 32'd0);

        // Single token placed at a chosen index, with DC + filler tokens ahead of it.
        for (int t = 0; t < 15; t++) begin
            do_reset();
            tok_q.delete();
            for (int k = 0; k < tbl[t].pre; k++) push_tok(16'h0001);
            push_tok(tbl[t].tok);
            run_tokens(t % 2 == 1, 1'b0);
            check($sformatf("tbl%0d_len", t), got_d.size(),
                  tbl[t].pre + tbl[t].zeros + int'(tbl[t].has_val));
            for (int k = 0; k < tbl[t].zeros; k++)
                if (tbl[t].pre + k < got_d.size())
                    check($sformatf("tbl%0d_zero%0d", t, k), 32'(got_d[tbl[t].pre + k]), 32'd0);
            if (tbl[t].has_val && tbl[t].pre + tbl[t].zeros < got_d.size())
                check($sformatf("tbl%0d_val", t), 32'(got_d[tbl[t].pre + tbl[t].zeros]), 32'(tbl[t].val));
            check($sformatf("tbl%0d_err", t), 32'(err), 32'(tbl[t].err));
        end

        // Basic block, no stall, then with random stalls.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            tok_q.delete();
            push_tok(16'h0005); push_tok(16'h2FFF); push_tok(16'h0000);
            run_tokens(pass == 1, pass == 1);
            compare_stream(pass == 0 ? "blkA" : "blkA_stall");
            if (got_d.size() >= 4) begin
                check("blkA_c0", 32'(got_d[0]), 32'h0005);
                check("blkA_c1", 32'(got_d[1]), 32'h0000);
                check("blkA_c2", 32'(got_d[2]), 32'h0000);
                check("blkA_c3", 32'(got_d[3]), 32'hFFFF);
            end
            check("blkA_n", got_d.size(), 64);
        end

        // ZRL chain then run/value, closed by EOB.
        do_reset();
        tok_q.delete();
        push_tok(16'h0001); push_tok(16'hF000); push_tok(16'hF000); push_tok(16'hF000);
        push_tok(16'h3007); push_tok(16'h0000);
        run_tokens(1'b0, 1'b0);
        compare_stream("zrl");
        if (got_d.size() > 52) check("zrl_idx52", 32'(got_d[52]), 32'h0007);
        check("zrl_n", got_d.size(), 64);

        // ZRL overflowing the block end; next token is DC.
        do_reset();
        tok_q.delete();
        push_tok(16'h0002);
        repeat (4) push_tok(16'hF000);
        push_tok(16'h0009);
        run_tokens(1'b1, 1'b0);
        compare_stream("ovf");
        check("ovf_n", got_d.size(), 65);
        if (got_d.size() > 64) check("ovf_dc", 32'(got_d[64]), 32'h0009);
        check("ovf_err", 32'(err), 32'd1);

        // Throughput/latency: R=0 tokens stream at one per cycle.
        do_reset();
        tok_q.delete();
        for (int k = 1; k <= 9; k++) push_tok(16'(k));
        run_tokens(1'b0, 1'b0);
        compare_stream("thru");
        for (int k = 0; k < acc_cyc.size() && k < out_cyc.size(); k++) begin
            check($sformatf("lat%0d", k), out_cyc[k], acc_cyc[k] + 1);
            check($sformatf("rate%0d", k), acc_cyc[k], acc_cyc[0] + k);
        end

        // End of stream mid-block.
        do_reset();
        tok_q.delete();
        push_tok(16'h0004); push_tok(16'h1003);
        tok_q.push_back('{e: 1'b1, d: 16'h1234});
        run_tokens(1'b1, 1'b0);
        compare_stream("eos");
        check("eos_n", got_d.size(), 65);
        @(negedge clock);
        parsedToken_v = 1'b1; parsedToken_d = 16'h0001; parsedToken_e = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock); #1;
            check($sformatf("eos_b%0d", k), 32'(parsedToken_b), 32'd1);
            check($sformatf("eos_v%0d", k), 32'(coef_v), 32'd0);
        end
        parsedToken_v = 1'b0;

        // Reset mid-block while stalled with err already set.
        do_reset();
        tok_q.delete();
        push_tok(16'h0002);
        repeat (4) push_tok(16'hF000);
        for (int k = 0; k < 20; k++) push_tok(16'h0001);
        run_tokens(1'b0, 1'b0);
        check("mid_err_pre", 32'(err), 32'd1);
        @(negedge clock);
        parsedToken_v = 1'b1; parsedToken_d = 16'hF000; parsedToken_e = 1'b0; coef_b = 1'b0;
        @(negedge clock);
        parsedToken_v = 1'b0; coef_b = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1; coef_b = 1'b0;
        #1;
        check("mid_rst_v", 32'(coef_v), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_b", 32'(parsedToken_b), 32'd0);
        tok_q.delete();
        push_tok(16'h3005);
        run_tokens(1'b0, 1'b0);
        compare_stream("mid_dc");

        // Randomized streams.
        for (int r = 0; r < 3; r++) begin
            int sel;
            do_reset();
            tok_q.delete();
            for (int k = 0; k < 150; k++) begin
                sel = $urandom_range(0, 19);
                if (sel < 2)       push_tok(16'h0000);
                else if (sel < 4)  push_tok(16'hF000);
                else if (sel < 6)  push_tok({4'($urandom_range(0, 15)), 12'($urandom)});
                else               push_tok({4'($urandom_range(0, 3)), 12'($urandom)});
            end
            if (r != 1) tok_q.push_back('{e: 1'b1, d: 16'h0});
            run_tokens(1'b1, 1'b1);
            compare_stream($sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
